ccd_timing_engine: RTL

CCD_TIMING_ENGINE -- requirements
Module: ccd_timing_engine

---
 rtl/ccd_timing_engine.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ccd_timing_engine.sv
// CCD sensor timing engine: sequences transfer, reset and line clock phases, ADC framing and
// pixel sample pulses from a programmable prescaler, configured through a Wishbone register file.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for run (CTRL.EN & i_enable); all raw phases low
// S_XFER   | charge transfer, raw phi_p high for XFER_s ticks
// S_PIX_R  | reset gate pulse, raw phi_r high for one tick
// S_PIX_L1 | first horizontal phase, raw phi_l1 high for one tick
// S_PIX_L2 | second horizontal phase, raw phi_l2 high; pixel sampled at its end
// S_FEND   | one-tick frame trailer; frame_done pulses on exit
module ccd_timing_engine #(
   parameter int unsigned CNT_W     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic        i_wb_clk,
   input  logic        i_wb_rst,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [31:0] i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_ack,
   output logic [31:0] o_wb_data,
   input  logic        i_enable,
   output logic        o_phi_p,
   output logic        o_phi_r,
   output logic        o_phi_l1,
   output logic        o_phi_l2,
   output logic        o_adc_frame,
   output logic        o_pixel_flag,
   output logic        o_control_signal,
   output logic        o_frame_done,
   output logic        o_busy
);

   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_DIV    = 8'h04;
   localparam logic [7:0] OFF_NPIX   = 8'h08;
   localparam logic [7:0] OFF_XFER   = 8'h0C;
   localparam logic [7:0] OFF_STATUS = 8'h10;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_XFER,
      S_PIX_R,
      S_PIX_L1,
      S_PIX_L2,
      S_FEND
   } state_t;

   state_t state;
   state_t nxt;

   logic             ctrl_en;
   logic             ctrl_cont;
   logic             ctrl_sel;
   logic [3:0]       ctrl_inv;
   logic [CNT_W-1:0] div_r;
   logic [CNT_W-1:0] npix_r;
   logic [CNT_W-1:0] xfer_r;

   logic [CNT_W-1:0] div_s;
   logic [CNT_W-1:0] npix_s;
   logic [CNT_W-1:0] xfer_s;
   logic [CNT_W-1:0] psc;
   logic [CNT_W-1:0] xfer_cnt;
   logic [CNT_W-1:0] pix_cnt;
   logic [15:0]      frame_cnt;

   logic             wb_req;
   logic [7:0]       offset;
   logic [31:0]      rd_data;
   logic             unused_wdata;

   logic             run;
   logic             tick;
   logic             xfer_entry;
   logic             frame_end;

   // Register file

   // Anything inside the 256-byte window is acked; unmapped offsets read 0.
   assign wb_req       = i_wb_cyc && i_wb_stb && !o_wb_ack
                         && (i_wb_addr[31:8] == BASE_ADDR[31:8]);
   assign offset       = i_wb_addr[7:0];
   assign unused_wdata = ^i_wb_data;

   always_comb begin
      rd_data = '0;
      case (offset)
         OFF_CTRL:   rd_data[7:0] = {ctrl_inv, 1'b0, ctrl_sel, ctrl_cont, ctrl_en};
         OFF_DIV:    rd_data[CNT_W-1:0] = div_r;
         OFF_NPIX:   rd_data[CNT_W-1:0] = npix_r;
         OFF_XFER:   rd_data[CNT_W-1:0] = xfer_r;
         OFF_STATUS: rd_data = {frame_cnt, 15'b0, o_busy};
         default:    rd_data = '0;
      endcase
   end

   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) begin
         o_wb_ack  <= 1'b0;
         o_wb_data <= '0;
         ctrl_en   <= 1'b0;
         ctrl_cont <= 1'b0;
         ctrl_sel  <= 1'b0;
         ctrl_inv  <= 4'h0;
         div_r     <= '0;
         npix_r    <= CNT_ONE;
         xfer_r    <= CNT_ONE;
      end else begin
         o_wb_ack  <= wb_req;
         o_wb_data <= (wb_req && !i_wb_we) ? rd_data : '0;
         if (wb_req && i_wb_we) begin
            case (offset)
               OFF_CTRL: begin
                  ctrl_en   <= i_wb_data[0];
                  ctrl_cont <= i_wb_data[1];
                  ctrl_sel  <= i_wb_data[2];
                  ctrl_inv  <= i_wb_data[7:4];
               end
               OFF_DIV:  div_r  <= i_wb_data[CNT_W-1:0];
               OFF_NPIX: npix_r <= i_wb_data[CNT_W-1:0];
               OFF_XFER: xfer_r <= i_wb_data[CNT_W-1:0];
               default:  ;
            endcase
         end
      end
   end

   // Sequencer

   assign run        = ctrl_en && i_enable;
   assign tick       = (state != S_IDLE) && (psc == div_s);
   assign xfer_entry = (nxt == S_XFER) && (state != S_XFER);
   // Losing run on the same cycle as the FEND tick counts as an abort, not a finished frame.
   assign frame_end  = (state == S_FEND) && tick && run;

   assign o_frame_done     = frame_end;
   assign o_pixel_flag     = (state == S_PIX_L2) && tick && run;
   assign o_busy           = (state != S_IDLE);
   assign o_control_signal = ctrl_sel ? o_phi_p : o_phi_r;

   always_comb begin
      nxt = state;
      if (state == S_IDLE) begin
         if (run) nxt = S_XFER;
      end else if (!run) begin
         nxt = S_IDLE;
      end else if (tick) begin
         case (state)
            S_XFER:   if (xfer_cnt == xfer_s - CNT_ONE) nxt = S_PIX_R;
            S_PIX_R:  nxt = S_PIX_L1;
            S_PIX_L1: nxt = S_PIX_L2;
            S_PIX_L2: nxt = (pix_cnt == npix_s - CNT_ONE) ? S_FEND : S_PIX_R;
            S_FEND:   nxt = ctrl_cont ? S_XFER : S_IDLE;
            default:  nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) begin
         state       <= S_IDLE;
         psc         <= '0;
         div_s       <= '0;
         npix_s      <= CNT_ONE;
         xfer_s      <= CNT_ONE;
         xfer_cnt    <= '0;
         pix_cnt     <= '0;
         frame_cnt   <= 16'h0000;
         o_phi_p     <= 1'b0;
         o_phi_r     <= 1'b0;
         o_phi_l1    <= 1'b0;
         o_phi_l2    <= 1'b0;
         o_adc_frame <= 1'b0;
      end else begin
         state <= nxt;

         if (state == S_IDLE || !run || tick) psc <= '0;
         else                                 psc <= psc + CNT_ONE;

         // Shadows are captured only here, so mid-frame writes wait for the next frame.
         if (xfer_entry) begin
            div_s    <= div_r;
            npix_s   <= (npix_r == '0) ? CNT_ONE : npix_r;
            xfer_s   <= (xfer_r == '0) ? CNT_ONE : xfer_r;
            xfer_cnt <= '0;
         end else if (state == S_XFER && tick && run) begin
            xfer_cnt <= xfer_cnt + CNT_ONE;
         end

         if (state != S_PIX_R && state != S_PIX_L1 && state != S_PIX_L2)
            pix_cnt <= '0;
         else if (state == S_PIX_L2 && tick && run)
            pix_cnt <= pix_cnt + CNT_ONE;

         if (frame_end) frame_cnt <= frame_cnt + 16'd1;

         // Phases follow the state being entered so they line up with it cycle for cycle.
         o_phi_p     <= (nxt == S_XFER)   ^ ctrl_inv[0];
         o_phi_r     <= (nxt == S_PIX_R)  ^ ctrl_inv[1];
         o_phi_l1    <= (nxt == S_PIX_L1) ^ ctrl_inv[2];
         o_phi_l2    <= (nxt == S_PIX_L2) ^ ctrl_inv[3];
         o_adc_frame <= (nxt == S_PIX_R) || (nxt == S_PIX_L1) || (nxt == S_PIX_L2);
      end
   end

endmodule
